// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//
// Pixel-timing generator that sits directly upstream of the sprite and
// palette renderers. It counts pixels (hc) and lines (vc) on vga_clk and
// produces the sync, blanking and position outputs for one pixel per cycle.
// The default parameters give 640x480 @ 60 Hz from a 25 MHz pixel clock.
//
// Optional feature (compile-time macro VGA_TIMING_FRAME_COUNT_EN):
//   when defined, a 16-bit frame_count output is added. It increments on the
//   same edge that asserts frame_start and wraps 0xFFFF -> 0. When the macro
//   is undefined the port and its counter do not exist.
//
// Ports:
//   vga_clk      in   1   pixel clock, all state on the rising edge
//   reset        in   1   asynchronous, active-high
//   hs           out  1   horizontal sync (active level = SYNC_POL), registered
//   vs           out  1   vertical sync   (active level = SYNC_POL), registered
//   blank        out  1   1 = visible pixel (colour allowed), 0 = blanking
//   DrawX        out  10  current pixel column, 0..H_TOTAL-1
//   DrawY        out  10  current line, 0..V_TOTAL-1
//   frame_start  out  1   one-cycle pulse while the position is (0,0)
//   frame_count  out  16  frames started since reset (macro builds only)
//
// All outputs come straight from flops, so renderers sampling DrawX/DrawY on
// the falling edge always see values that settled at the preceding rising edge.
// ----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic        vga_clk,
    input  logic        reset,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        frame_start
`ifdef VGA_TIMING_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_geometry
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
    endgenerate

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Decode thresholds are kept one bit wider than the counters so that a
    // region ending exactly at 1024 still compares correctly.
    localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
    localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
    localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_q, blank_d;
    logic       frame_start_q, frame_start_d;
`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [15:0] frame_count_q, frame_count_d;
`endif

    logic [10:0] hc_ext;
    logic [10:0] vc_ext;

    // Next-state counters; the decoded outputs are computed from these so the
    // registered flags describe the same pixel as the registered counters.
    always_comb begin
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = 10'd0;
            if (vc_q == V_LAST) begin
                vc_d = 10'd0;
            end else begin
                vc_d = vc_q + 10'd1;
            end
        end

        hc_ext = {1'b0, hc_d};
        vc_ext = {1'b0, vc_d};

        hs_d = ~SYNC_POL;
        if (hc_ext >= HS_START && hc_ext < HS_END) begin
            hs_d = SYNC_POL;
        end

        vs_d = ~SYNC_POL;
        if (vc_ext >= VS_START && vc_ext < VS_END) begin
            vs_d = SYNC_POL;
        end

        blank_d       = (hc_ext < H_VIS_END) && (vc_ext < V_VIS_END);
        frame_start_d = (hc_d == 10'd0) && (vc_d == 10'd0);

`ifdef VGA_TIMING_FRAME_COUNT_EN
        frame_count_d = frame_count_q;
        if (frame_start_d) begin
            frame_count_d = frame_count_q + 16'd1;
        end
`endif
    end

    // Reset parks the counters on the last pixel of the frame so the first
    // edge after release lands on (0,0) with frame_start asserted.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hc_q          <= H_LAST;
            vc_q          <= V_LAST;
            hs_q          <= ~SYNC_POL;
            vs_q          <= ~SYNC_POL;
            blank_q       <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef VGA_TIMING_FRAME_COUNT_EN
            frame_count_q <= 16'd0;
`endif
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_q       <= blank_d;
            frame_start_q <= frame_start_d;
`ifdef VGA_TIMING_FRAME_COUNT_EN
            frame_count_q <= frame_count_d;
`endif
        end
    end

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank       = blank_q;
    assign frame_start = frame_start_q;
`ifdef VGA_TIMING_FRAME_COUNT_EN
    assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances share clock and reset: u_def uses the 640x480 defaults for the
// line-level and reset checks, u_small uses a 16x10 geometry with active-high
// syncs so whole frames, frame wrap and frame_start spacing fit in a short run.
// Expected positions come from a cycle index kept by the bench.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_timing_gen;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT instances ----------------
    logic       hs_def, vs_def, blank_def, fs_def;
    logic [9:0] x_def, y_def;
    logic       hs_s, vs_s, blank_s, fs_s;
    logic [9:0] x_s, y_s;
`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [15:0] fc_def, fc_s;
`endif

    vga_timing_gen u_def (
        .vga_clk     (clk),
        .reset       (rst),
        .hs          (hs_def),
        .vs          (vs_def),
        .blank       (blank_def),
        .DrawX       (x_def),
        .DrawY       (y_def),
        .frame_start (fs_def)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        ,
        .frame_count (fc_def)
`endif
    );

    // 16 columns (8 visible, sync 10..12), 10 lines (6 visible, sync 7..8)
    vga_timing_gen #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
        .V_VISIBLE (6), .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
        .SYNC_POL  (1'b1)
    ) u_small (
        .vga_clk     (clk),
        .reset       (rst),
        .hs          (hs_s),
        .vs          (vs_s),
        .blank       (blank_s),
        .DrawX       (x_s),
        .DrawY       (y_s),
        .frame_start (fs_s)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        ,
        .frame_count (fc_s)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Cycles since reset release; -1 while in (or just entering) reset.
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= -1;
        else     cyc <= cyc + 1;
    end

    // Every-cycle check of both instances against the position implied by cyc.
    int tick = 0;
    int last_fs_tick = -1;
    always @(negedge clk) begin
        automatic int xd, yd, xs, ys;
        tick++;
        if (cyc < 0) begin
            check_eq("cyc_rst_x_def", x_def, 799);
            check_eq("cyc_rst_y_def", y_def, 524);
            check_eq("cyc_rst_blank_def", blank_def, 0);
            check_eq("cyc_rst_sync_def", {hs_def, vs_def, fs_def}, 3'b110);
            check_eq("cyc_rst_pos_s", {x_s, y_s}, {10'd15, 10'd9});
            check_eq("cyc_rst_flags_s", {hs_s, vs_s, blank_s, fs_s}, 4'b0000);
        end else begin
            xd = cyc % 800;
            yd = (cyc / 800) % 525;
            xs = cyc % 16;
            ys = (cyc / 16) % 10;
            check_eq("cyc_x_def", x_def, xd);
            check_eq("cyc_y_def", y_def, yd);
            check_eq("cyc_hs_def", hs_def, !(xd >= 656 && xd < 752));
            check_eq("cyc_vs_def", vs_def, !(yd >= 490 && yd < 492));
            check_eq("cyc_blank_def", blank_def, (xd < 640) && (yd < 480));
            check_eq("cyc_fs_def", fs_def, (xd == 0) && (yd == 0));
            check_eq("cyc_x_s", x_s, xs);
            check_eq("cyc_y_s", y_s, ys);
            check_eq("cyc_hs_s", hs_s, (xs >= 10 && xs < 13));
            check_eq("cyc_vs_s", vs_s, (ys >= 7 && ys < 9));
            check_eq("cyc_blank_s", blank_s, (xs < 8) && (ys < 6));
            check_eq("cyc_fs_s", fs_s, (xs == 0) && (ys == 0));
        end
        // Spacing between frame_start pulses, forgotten across resets.
        if (rst) begin
            last_fs_tick = -1;
        end else if (fs_s) begin
            if (last_fs_tick >= 0) check_eq("fs_period_s", tick - last_fs_tick, 160);
            last_fs_tick = tick;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset held for 3 cycles
        run_cycles(3);
        check_eq("rst_drawx", x_def, 10'd799);
        check_eq("rst_drawy", y_def, 10'd524);
        check_eq("rst_blank", blank_def, 1'b0);
        check_eq("rst_hs_vs", {hs_def, vs_def}, 2'b11);
        check_eq("rst_fs", fs_def, 1'b0);
`ifdef VGA_TIMING_FRAME_COUNT_EN
        check_eq("rst_fc", fc_def, 16'd0);
`endif
        #1 rst = 1'b0;

        // First edge after release: cyc 0
        run_cycles(1);
        check_eq("first_pos", {x_def, y_def}, {10'd0, 10'd0});
        check_eq("first_blank", blank_def, 1'b1);
        check_eq("first_fs", fs_def, 1'b1);

        run_cycles(639);                    // cyc 639
        check_eq("x639_blank", blank_def, 1'b1);
        run_cycles(1);                      // cyc 640
        check_eq("x640_blank", blank_def, 1'b0);
        run_cycles(15);                     // cyc 655
        check_eq("x655_hs", hs_def, 1'b1);
        run_cycles(1);                      // cyc 656
        check_eq("x656_hs", hs_def, 1'b0);
        run_cycles(95);                     // cyc 751
        check_eq("x751_hs", hs_def, 1'b0);
        run_cycles(1);                      // cyc 752
        check_eq("x752_hs", hs_def, 1'b1);
        run_cycles(47);                     // cyc 799
        check_eq("x799_pos", {x_def, y_def}, {10'd799, 10'd0});
        run_cycles(1);                      // cyc 800: line wrap
        check_eq("wrap_pos", {x_def, y_def}, {10'd0, 10'd1});
        check_eq("wrap_blank", blank_def, 1'b1);
        check_eq("wrap_fs", fs_def, 1'b0);

        run_cycles(1100);                   // cyc 1900 -> (300,2)
        check_eq("mid_pos", {x_def, y_def}, {10'd300, 10'd2});

        // One-cycle reset pulse mid-line; outputs must change before any edge
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("async_drawx", x_def, 10'd799);
        check_eq("async_drawy", y_def, 10'd524);
        check_eq("async_blank", blank_def, 1'b0);
        check_eq("async_hs_vs", {hs_def, vs_def}, 2'b11);
        check_eq("async_small", {x_s, y_s}, {10'd15, 10'd9});
        release_reset();
        run_cycles(1);                      // cyc 0 again
        check_eq("restart_pos", {x_def, y_def}, {10'd0, 10'd0});
        check_eq("restart_fs", {fs_def, blank_def}, 2'b11);
`ifdef VGA_TIMING_FRAME_COUNT_EN
        check_eq("fc_frame1_def", fc_def, 16'd1);
        check_eq("fc_frame1_s", fc_s, 16'd1);
`endif

        // Small instance through full frames
        run_cycles(112);                    // cyc 112 -> (0,7)
        check_eq("s_vs_line7", vs_s, 1'b1);
        check_eq("s_blank_line7", blank_s, 1'b0);
        run_cycles(32);                     // cyc 144 -> (0,9)
        check_eq("s_vs_line9", vs_s, 1'b0);
        run_cycles(15);                     // cyc 159 -> (15,9)
        check_eq("s_last_pos", {x_s, y_s}, {10'd15, 10'd9});
        run_cycles(1);                      // cyc 160: frame wrap
        check_eq("s_frame_wrap", {x_s, y_s}, {10'd0, 10'd0});
        check_eq("s_frame_fs", fs_s, 1'b1);
`ifdef VGA_TIMING_FRAME_COUNT_EN
        check_eq("fc_frame2_s", fc_s, 16'd2);
        run_cycles(160);                    // cyc 320
        check_eq("fc_frame3_s", fc_s, 16'd3);
        check_eq("fc_def_hold", fc_def, 16'd1);
        force u_small.frame_count_q = 16'hFFFF;
        #1 release u_small.frame_count_q;
        run_cycles(159);                    // cyc 479
        check_eq("fc_forced", fc_s, 16'hFFFF);
        run_cycles(1);                      // cyc 480
        check_eq("fc_wrap", fc_s, 16'd0);
`else
        run_cycles(320);
`endif
        run_cycles(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
